// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and geometry for the direct-mapped data cache
package dcache_pkg;

  localparam int DCACHE_SETS = 16;
  localparam int IW          = $clog2(DCACHE_SETS);
  localparam int TW          = 30 - IW;

  // word address split into tag / frame index / ignored byte offset
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [IW-1:0] idx;
    logic [1:0]    bytoff;
  } dcachef_t;

  typedef struct packed {
    logic          valid;
    logic          dirty;
    logic [TW-1:0] tag;
    logic [31:0]   data;
  } dframe_t;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    FLUSH,
    DONE
  } dcache_state_t;

  // memory word address of the block held in frame idx with the given tag
  function automatic logic [31:0] frame_addr(input logic [TW-1:0] tag, input logic [IW-1:0] idx);
    return {tag, idx, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_frame_array.sv
// rtl/dcache_frame_array.sv - frame storage, one combinational read port and one write port
module dcache_frame_array
  import dcache_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  input  logic [IW-1:0] rd_idx_i,
  output dframe_t       rd_frame_o,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  dframe_t       wr_frame_i
);

  dframe_t frames_q [DCACHE_SETS];

  // reset invalidates every frame; otherwise a single frame write per cycle
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DCACHE_SETS; i++) begin
        frames_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      frames_q[wr_idx_i] <= wr_frame_i;
    end
  end

  assign rd_frame_o = frames_q[rd_idx_i];

endmodule

// File: rtl/dm_dcache.sv
// rtl/dm_dcache.sv - direct-mapped write-back data cache with halt flush (option: DCACHE_ATOMIC_EN adds LL/SC)
module dm_dcache
  import dcache_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  dcache_state_t state_q, state_d;
  logic [IW-1:0] flush_idx_q, flush_idx_d;

  dcachef_t      req_f;
  dframe_t       frame;
  dframe_t       wr_frame;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic          wr_en;
  logic          req;
  logic          hit;
  logic          flush_adv;
  logic          sc_ok;
  logic          sc_fail;
  logic          unused_inputs;

  assign req_f = dcachef_t'(dmemaddr);
  assign req   = dmemREN | dmemWEN;

  // the flush walk owns the read port; otherwise it follows the request index
  assign rd_idx = (state_q == FLUSH) ? flush_idx_q : req_f.idx;
  assign hit    = frame.valid && (frame.tag == req_f.tag);

  dcache_frame_array u_frames (
    .CLK        (CLK),
    .nRST       (nRST),
    .rd_idx_i   (rd_idx),
    .rd_frame_o (frame),
    .wr_en_i    (wr_en),
    .wr_idx_i   (wr_idx),
    .wr_frame_i (wr_frame)
  );

`ifdef DCACHE_ATOMIC_EN
  logic        link_valid_q, link_valid_d;
  logic [29:0] link_addr_q, link_addr_d;
  logic        link_match;

  assign link_match = link_valid_q && (link_addr_q == dmemaddr[31:2]);
  assign sc_ok      = datomic & dmemWEN & link_match;
  // a failed SC is answered at once without touching the frame or memory
  assign sc_fail    = datomic & dmemWEN & ~link_match;

  // link is set by an acknowledged LL and dropped by a successful SC or a plain write to it
  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (dhit) begin
      if (datomic && dmemREN && !dmemWEN) begin
        link_valid_d = 1'b1;
        link_addr_d  = dmemaddr[31:2];
      end else if (sc_ok) begin
        link_valid_d = 1'b0;
      end else if (dmemWEN && !datomic && link_match) begin
        link_valid_d = 1'b0;
      end
    end
  end

  // link register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end
`else
  assign sc_ok   = 1'b0;
  assign sc_fail = 1'b0;
`endif

  // byte offset is architecturally ignored; datomic is unused without the atomic option
  assign unused_inputs = ^{req_f.bytoff, datomic};

  // state and flush index registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
    end
  end

  // next state, frame update and all handshake outputs
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    dhit        = 1'b0;
    dmemload    = '0;
    flushed     = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = '0;
    dstore      = '0;
    wr_en       = 1'b0;
    wr_idx      = req_f.idx;
    wr_frame    = frame;
    flush_adv   = 1'b0;

    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end else if (req) begin
          if (sc_fail) begin
            dhit = 1'b1;
          end else if (hit) begin
            dhit = 1'b1;
            if (dmemWEN) begin
              wr_en          = 1'b1;
              wr_frame.dirty = 1'b1;
              wr_frame.data  = dmemstore;
              dmemload       = {31'b0, sc_ok};
            end else begin
              dmemload = frame.data;
            end
          end else begin
            state_d = (frame.valid && frame.dirty) ? WB : FILL;
          end
        end
      end

      WB: begin
        dWEN   = 1'b1;
        daddr  = frame_addr(frame.tag, req_f.idx);
        dstore = frame.data;
        if (!dwait) begin
          state_d = FILL;
        end
      end

      FILL: begin
        dREN  = 1'b1;
        daddr = {dmemaddr[31:2], 2'b00};
        if (!dwait) begin
          wr_en          = 1'b1;
          wr_frame.valid = 1'b1;
          wr_frame.dirty = 1'b0;
          wr_frame.tag   = req_f.tag;
          wr_frame.data  = dload;
          state_d        = IDLE;
        end
      end

      FLUSH: begin
        if (frame.valid && frame.dirty) begin
          dWEN   = 1'b1;
          daddr  = frame_addr(frame.tag, flush_idx_q);
          dstore = frame.data;
          if (!dwait) begin
            wr_en          = 1'b1;
            wr_idx         = flush_idx_q;
            wr_frame.dirty = 1'b0;
            flush_adv      = 1'b1;
          end
        end else begin
          flush_adv = 1'b1;
        end
        if (flush_adv) begin
          if (flush_idx_q == IW'(DCACHE_SETS - 1)) begin
            state_d = DONE;
          end else begin
            flush_idx_d = flush_idx_q + 1'b1;
          end
        end
      end

      DONE: begin
        flushed = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_dcache.sv
// tb/tb_dm_dcache.sv - self-checking bench for dm_dcache (define DCACHE_ATOMIC_EN to cover LL/SC)
module tb_dm_dcache;

  logic        CLK;
  logic        nRST;
  logic        halt;
  logic        dmemREN;
  logic        dmemWEN;
  logic        datomic;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  int checks = 0;
  int errors = 0;
  int lat    = 2;
  int wait_cnt;

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
  } mop_t;

  logic [31:0] mem    [bit [31:0]];
  logic [31:0] golden [bit [31:0]];
  mop_t        trace  [$];
  mop_t        op;
  logic [31:0] mon_aw;
  logic [31:0] mon_exp;
`ifdef DCACHE_ATOMIC_EN
  bit          link_v;
  logic [31:0] link_a;
`endif

  dm_dcache dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .halt      (halt),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .datomic   (datomic),
    .dmemaddr  (dmemaddr),
    .dmemstore (dmemstore),
    .dhit      (dhit),
    .dmemload  (dmemload),
    .flushed   (flushed),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dload     (dload),
    .dwait     (dwait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function logic [31:0] golden_rd(input logic [31:0] a);
    return golden.exists(a) ? golden[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // memory: busy for lat cycles, completes on the first dwait=0 cycle
  assign dwait = (dREN | dWEN) && (wait_cnt < lat);

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) wait_cnt <= 0;
    else if ((dREN | dWEN) && !dwait) wait_cnt <= 0;
    else if (dREN | dWEN) wait_cnt <= wait_cnt + 1;
  end

  // reset discards dirty frames: the datapath view falls back to memory contents
  always @(negedge nRST) begin
    golden = mem;
`ifdef DCACHE_ATOMIC_EN
    link_v = 1'b0;
`endif
  end

  // per-cycle compare against the value model, plus memory bookkeeping
  always @(negedge CLK) begin
    if (nRST) begin
      mon_aw = {dmemaddr[31:2], 2'b00};
      check("rd_wr_exclusive", {31'b0, dREN & dWEN}, 32'd0);
      if (flushed) check("done_quiet", {29'b0, dREN, dWEN, dhit}, 32'd0);
      if (dREN) check("fill_addr", daddr, mon_aw);
      if (dWEN && !dwait) begin
        check("wb_data", dstore, golden_rd(daddr));
        mem[daddr] = dstore;
        op.we = 1'b1; op.a = daddr; op.d = dstore;
        trace.push_back(op);
      end
      if (dREN && !dwait) begin
        op.we = 1'b0; op.a = daddr; op.d = dload;
        trace.push_back(op);
      end
      if (dhit) begin
        check("hit_quiet", {30'b0, dREN, dWEN}, 32'd0);
        check("hit_blocked", {30'b0, halt, flushed}, 32'd0);
        if (!dmemWEN) begin
          mon_exp = golden_rd(mon_aw);
`ifdef DCACHE_ATOMIC_EN
          if (datomic) begin
            link_v = 1'b1;
            link_a = mon_aw;
          end
`endif
        end else begin
          mon_exp = 32'd0;
`ifdef DCACHE_ATOMIC_EN
          if (datomic) begin
            if (link_v && link_a == mon_aw) begin
              mon_exp        = 32'd1;
              golden[mon_aw] = dmemstore;
              link_v         = 1'b0;
            end
          end else begin
            golden[mon_aw] = dmemstore;
            if (link_v && link_a == mon_aw) link_v = 1'b0;
          end
`else
          golden[mon_aw] = dmemstore;
`endif
        end
        check("dmemload", dmemload, mon_exp);
      end
    end
    dload = mem_rd(daddr);
  end

  task automatic do_req(input logic ren, input logic wen, input logic at,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] ld, output int waits);
    dmemREN   = ren;
    dmemWEN   = wen;
    datomic   = at;
    dmemaddr  = a;
    dmemstore = d;
    for (waits = 0; waits < 60; waits++) begin
      @(negedge CLK);
      if (dhit) break;
    end
    if (waits >= 60) check("req_timeout", 32'd1, 32'd0);
    ld = dmemload;
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    datomic = 1'b0;
  endtask

  task automatic chk_op(input int i, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (i < trace.size()) begin
      check("trace_we", {31'b0, trace[i].we}, {31'b0, we});
      check("trace_addr", trace[i].a, a);
      if (we) check("trace_data", trace[i].d, d);
    end else begin
      check("trace_len", trace.size(), i + 1);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2 nRST = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] ld;
    int          w;
    int          n;

    nRST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
    dmemaddr = '0; dmemstore = '0; dload = '0;
    #2 nRST = 1'b0;
    @(negedge CLK);
    check("rst_dhit", {31'b0, dhit}, 32'd0);
    check("rst_flushed", {31'b0, flushed}, 32'd0);
    check("rst_dren", {31'b0, dREN}, 32'd0);
    check("rst_dwen", {31'b0, dWEN}, 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dstore", dstore, 32'd0);
    check("rst_dmemload", dmemload, 32'd0);
    mem[32'h40]    = 32'hDEAD_BEEF;
    golden[32'h40] = 32'hDEAD_BEEF;
    @(posedge CLK);
    #1 nRST = 1'b1;

    // 1: cold read, two busy cycles
    trace.delete(); lat = 2;
    do_req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, ld, w);
    check("t1_load", ld, 32'hDEAD_BEEF);
    check("t1_latency", w, 32'd4);
    check("t1_ops", trace.size(), 32'd1);
    chk_op(0, 1'b0, 32'h40, 32'h0);

    // 2: write hit then read hit, no memory traffic
    trace.delete();
    do_req(1'b0, 1'b1, 1'b0, 32'h40, 32'h1234_5678, ld, w);
    check("t2_wr_latency", w, 32'd0);
    do_req(1'b1, 1'b0, 1'b0, 32'h43, 32'h0, ld, w);
    check("t2_load", ld, 32'h1234_5678);
    check("t2_rd_latency", w, 32'd0);
    check("t2_ops", trace.size(), 32'd0);

    // 3: conflicting read evicts the dirty frame first
    trace.delete(); lat = 1;
    do_req(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, ld, w);
    check("t3_load", ld, 32'h5A5A_0080);
    check("t3_latency", w, 32'd5);
    check("t3_ops", trace.size(), 32'd2);
    chk_op(0, 1'b1, 32'h40, 32'h1234_5678);
    chk_op(1, 1'b0, 32'h80, 32'h0);

`ifdef DCACHE_ATOMIC_EN
    // 5: LL/SC success, then SC broken by an intervening plain write
    do_req(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, ld, w);
    check("t5_ll_load", ld, 32'h1234_5678);
    do_req(1'b0, 1'b1, 1'b1, 32'h40, 32'd7, ld, w);
    check("t5_sc_ok", ld, 32'd1);
    do_req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, ld, w);
    check("t5_after_sc", ld, 32'd7);
    do_req(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, ld, w);
    do_req(1'b0, 1'b1, 1'b0, 32'h40, 32'h55, ld, w);
    trace.delete();
    do_req(1'b0, 1'b1, 1'b1, 32'h40, 32'd9, ld, w);
    check("t5_sc_fail", ld, 32'd0);
    check("t5_sc_fail_latency", w, 32'd0);
    check("t5_sc_fail_ops", trace.size(), 32'd0);
    do_req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, ld, w);
    check("t5_after_fail", ld, 32'h55);
`endif

    // 6: reset in the middle of a fill
    do_reset();
    lat = 3;
    dmemREN = 1'b1; dmemaddr = 32'h40;
    for (n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (dREN) break;
    end
    check("t6_fill_seen", {31'b0, dREN}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("t6_rst_dren", {31'b0, dREN}, 32'd0);
    check("t6_rst_dwen", {31'b0, dWEN}, 32'd0);
    check("t6_rst_daddr", daddr, 32'd0);
    @(posedge CLK);
    #1 dmemREN = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    trace.delete(); lat = 2;
    do_req(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, ld, w);
    check("t6_remiss_latency", w, 32'd4);
    check("t6_load", ld, 32'h1234_5678);
    check("t6_ops", trace.size(), 32'd1);

    // 4: flush of two dirty frames, then terminal DONE
    do_reset();
    lat = 1;
    do_req(1'b0, 1'b1, 1'b0, 32'h40, 32'hAAAA_0001, ld, w);
    do_req(1'b0, 1'b1, 1'b0, 32'h54, 32'hBBBB_0005, ld, w);
    trace.delete();
    halt = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (flushed) break;
    end
    check("t4_flushed", {31'b0, flushed}, 32'd1);
    check("t4_ops", trace.size(), 32'd2);
    chk_op(0, 1'b1, 32'h40, 32'hAAAA_0001);
    chk_op(1, 1'b1, 32'h54, 32'hBBBB_0005);
    halt = 1'b0;
    dmemREN = 1'b1; dmemaddr = 32'h80;
    w = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (dhit) w++;
    end
    dmemREN = 1'b0;
    check("t4_no_hits", w, 32'd0);
    check("t4_sticky", {31'b0, flushed}, 32'd1);
    check("t4_ops_after", trace.size(), 32'd2);
    check("t4_mem_40", mem_rd(32'h40), 32'hAAAA_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
